// File: rtl/pong_ball_engine.sv
`timescale 1ns/1ps
// pong_ball_engine
//   Ball object for the Pong datapath. On every clk_1ms tick the ball is
//   moved, reflected off the top/bottom walls and both paddles, and misses
//   are turned into one-tick point pulses and score increments. A
//   serve/play/point/over state machine sequences the rally, and a
//   combinational overlay (ball_on/rgb_ball) feeds the VGA mux.
//
//   Optional feature macro: BALL_SPEEDUP_EN
//     defined   - 3-bit step register, +1 per paddle hit (saturates at 4),
//                 reloaded to 1 after every point
//     undefined - constant step of 1
//
// Ports
//   clk_1ms                game tick clock (1 kHz)
//   reset                  synchronous, active-low reset
//   x, y                   current VGA scan pixel
//   x_paddle1, y_paddle1   left paddle centre
//   x_paddle2, y_paddle2   right paddle centre
//   x_ball, y_ball         ball centre (registered)
//   ball_on                scan pixel lies inside the ball
//   rgb_ball               ball colour (white)
//   point_p1, point_p2     one-tick pulse: player 1 / player 2 scored
//   score1, score2         scores, 0..MAX_SCORE
//   game_over              high once either score reaches MAX_SCORE
module pong_ball_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 16,
    parameter int PADDLE_H    = 80,
    parameter int SERVE_DELAY = 1000,
    parameter int MAX_SCORE   = 9
) (
    input  logic        clk_1ms,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  x_paddle1,
    input  logic [9:0]  y_paddle1,
    input  logic [9:0]  x_paddle2,
    input  logic [9:0]  y_paddle2,
    output logic [9:0]  x_ball,
    output logic [9:0]  y_ball,
    output logic        ball_on,
    output logic [11:0] rgb_ball,
    output logic        point_p1,
    output logic        point_p2,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic        game_over
);

    localparam int HALF = BALL_SIZE / 2;
    localparam int CW   = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY - 1);
    localparam logic [9:0]    X_CENTRE   = 10'(H_ACTIVE / 2);
    localparam logic [9:0]    Y_CENTRE   = 10'(V_ACTIVE / 2);
    localparam logic [9:0]    Y_MIN      = 10'(HALF);
    localparam logic [9:0]    Y_MAX      = 10'(V_ACTIVE - 1 - HALF);
    localparam logic [3:0]    MAX_S      = 4'(MAX_SCORE);

    localparam logic signed [10:0] S_HALF = 11'(HALF);
    localparam logic signed [10:0] S_PW2  = 11'(PADDLE_W / 2);
    localparam logic signed [10:0] S_PH2  = 11'(PADDLE_H / 2);
    localparam logic signed [10:0] S_VBOT = 11'(V_ACTIVE - 1);
    localparam logic signed [10:0] S_HRGT = 11'(H_ACTIVE);

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        POINT,
        OVER
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dir_x, dir_x_nxt;
    logic          dir_y, dir_y_nxt;
    logic [9:0]    x_ball_nxt, y_ball_nxt;
    logic [3:0]    score1_nxt, score2_nxt;
    logic          point_p1_nxt, point_p2_nxt;
    logic          game_over_nxt;
    logic [2:0]    step;

`ifdef BALL_SPEEDUP_EN
    logic [2:0]    step_nxt;
`else
    assign step = 3'd1;
`endif

    // Edge arithmetic in 11-bit signed so that "centre - HALF" never wraps.
    logic signed [10:0] bx, by, sx, sy;
    logic signed [10:0] b_left, b_right, b_top, b_bot;
    logic signed [10:0] p1_left, p1_right, p1_top, p1_bot;
    logic signed [10:0] p2_left, p2_right, p2_top, p2_bot;

    assign bx      = signed'({1'b0, x_ball});
    assign by      = signed'({1'b0, y_ball});
    assign sx      = signed'({1'b0, x});
    assign sy      = signed'({1'b0, y});
    assign b_left  = bx - S_HALF;
    assign b_right = bx + S_HALF;
    assign b_top   = by - S_HALF;
    assign b_bot   = by + S_HALF;

    assign p1_left  = signed'({1'b0, x_paddle1}) - S_PW2;
    assign p1_right = signed'({1'b0, x_paddle1}) + S_PW2;
    assign p1_top   = signed'({1'b0, y_paddle1}) - S_PH2;
    assign p1_bot   = signed'({1'b0, y_paddle1}) + S_PH2;
    assign p2_left  = signed'({1'b0, x_paddle2}) - S_PW2;
    assign p2_right = signed'({1'b0, x_paddle2}) + S_PW2;
    assign p2_top   = signed'({1'b0, y_paddle2}) - S_PH2;
    assign p2_bot   = signed'({1'b0, y_paddle2}) + S_PH2;

    // Paddle tests only fire when the ball is travelling toward the paddle,
    // so a ball approaching from behind passes straight through.
    logic hit_l, hit_r, hit, miss_l, miss_r;

    assign hit_l = !dir_x
                && (b_left >= p1_left) && (b_left <= p1_right)
                && (b_bot >= p1_top) && (b_top < p1_bot);
    assign hit_r = dir_x
                && (b_right >= p2_left) && (b_right <= p2_right)
                && (b_bot >= p2_top) && (b_top < p2_bot);
    assign hit    = hit_l | hit_r;
    assign miss_l = !hit && (b_left <= 11'sd0);
    assign miss_r = !hit && !miss_l && (b_right >= S_HRGT);

    logic play_dx, play_dy;

    assign play_dx = hit_l ? 1'b1 : (hit_r ? 1'b0 : dir_x);

    always_comb begin
        play_dy = dir_y;
        if (!dir_y && (b_top <= 11'sd0)) begin
            play_dy = 1'b1;
        end else if (dir_y && (b_bot >= S_VBOT)) begin
            play_dy = 1'b0;
        end
    end

    // Moves use the directions already updated this tick. The centre always
    // sits at least HALF from the edges and step <= HALF, so 10-bit unsigned
    // subtraction cannot wrap here.
    logic [9:0] step10, mv_x, mv_y, mv_y_clamped;

    assign step10 = {7'd0, step};
    assign mv_x   = play_dx ? (x_ball + step10) : (x_ball - step10);
    assign mv_y   = play_dy ? (y_ball + step10) : (y_ball - step10);

    always_comb begin
        mv_y_clamped = mv_y;
        if (mv_y < Y_MIN) begin
            mv_y_clamped = Y_MIN;
        end else if (mv_y > Y_MAX) begin
            mv_y_clamped = Y_MAX;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        dir_x_nxt     = dir_x;
        dir_y_nxt     = dir_y;
        x_ball_nxt    = x_ball;
        y_ball_nxt    = y_ball;
        score1_nxt    = score1;
        score2_nxt    = score2;
        point_p1_nxt  = 1'b0;
        point_p2_nxt  = 1'b0;
        game_over_nxt = game_over;
`ifdef BALL_SPEEDUP_EN
        step_nxt      = step;
`endif
        case (state)
            SERVE: begin
                x_ball_nxt = X_CENTRE;
                y_ball_nxt = Y_CENTRE;
                if (cnt == SERVE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = PLAY;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PLAY: begin
                dir_x_nxt  = play_dx;
                dir_y_nxt  = play_dy;
                x_ball_nxt = mv_x;
                y_ball_nxt = mv_y_clamped;
`ifdef BALL_SPEEDUP_EN
                if (hit && (step < 3'd4)) begin
                    step_nxt = step + 3'd1;
                end
`endif
                if (miss_l) begin
                    point_p2_nxt = 1'b1;
                    if (score2 != MAX_S) begin
                        score2_nxt = score2 + 4'd1;
                    end
                    state_nxt = POINT;
                end else if (miss_r) begin
                    point_p1_nxt = 1'b1;
                    if (score1 != MAX_S) begin
                        score1_nxt = score1 + 4'd1;
                    end
                    state_nxt = POINT;
                end
            end
            POINT: begin
                x_ball_nxt = X_CENTRE;
                y_ball_nxt = Y_CENTRE;
                // Serve toward the loser: player 1 scoring means player 2
                // (right side) lost, so the ball heads right.
                dir_x_nxt  = point_p1;
`ifdef BALL_SPEEDUP_EN
                step_nxt   = 3'd1;
`endif
                if ((score1 == MAX_S) || (score2 == MAX_S)) begin
                    game_over_nxt = 1'b1;
                    state_nxt     = OVER;
                end else begin
                    state_nxt = SERVE;
                end
            end
            OVER: begin
                x_ball_nxt    = X_CENTRE;
                y_ball_nxt    = Y_CENTRE;
                game_over_nxt = 1'b1;
            end
            default: begin
                state_nxt = SERVE;
            end
        endcase
    end

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            state     <= SERVE;
            cnt       <= '0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            x_ball    <= X_CENTRE;
            y_ball    <= Y_CENTRE;
            score1    <= '0;
            score2    <= '0;
            point_p1  <= 1'b0;
            point_p2  <= 1'b0;
            game_over <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            step      <= 3'd1;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dir_x     <= dir_x_nxt;
            dir_y     <= dir_y_nxt;
            x_ball    <= x_ball_nxt;
            y_ball    <= y_ball_nxt;
            score1    <= score1_nxt;
            score2    <= score2_nxt;
            point_p1  <= point_p1_nxt;
            point_p2  <= point_p2_nxt;
            game_over <= game_over_nxt;
`ifdef BALL_SPEEDUP_EN
            step      <= step_nxt;
`endif
        end
    end

    // Ball square covers [centre-HALF, centre+HALF) on both axes.
    assign ball_on  = (sx >= b_left) && (sx < b_right)
                   && (sy >= b_top) && (sy < b_bot);
    assign rgb_ball = 12'hFFF;

endmodule
